// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and fetch-scheduler state encoding.
// Used by the sync generator and by line_fetch_sched.
package vga_timing_pkg;

    localparam logic [9:0] H_VIEW_640X480 = 10'd640;
    localparam logic [9:0] V_VIEW_640X480 = 10'd480;
    localparam logic [9:0] V_MAX_640X480  = 10'd524;

    localparam logic [9:0] H_VIEW_360X900 = 10'd360;
    localparam logic [9:0] V_VIEW_360X900 = 10'd900;
    localparam logic [9:0] V_MAX_360X900  = 10'd931;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BLANK,
        ST_ISSUE,
        ST_BUSY,
        ST_READY
    } fetch_state_t;

    function automatic logic [9:0] h_view(input logic m);
        return m ? H_VIEW_360X900 : H_VIEW_640X480;
    endfunction

    function automatic logic [9:0] v_view(input logic m);
        return m ? V_VIEW_360X900 : V_VIEW_640X480;
    endfunction

    function automatic logic [9:0] v_max(input logic m);
        return m ? V_MAX_360X900 : V_MAX_640X480;
    endfunction

endpackage

// File: rtl/line_fetch_sched.sv
// Schedules one SPI-ROM line fetch per displayed line during horizontal
// blank and ping-pongs the two line buffers at the end of each line.
module line_fetch_sched
    import vga_timing_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR   = 24'h000000,
    parameter logic [23:0] LINE_STRIDE = 24'd64,
    parameter logic [7:0]  LINE_BYTES  = 8'd40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        mode,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic        hmax,
    input  logic        vmax,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [23:0] cmd_addr,
    output logic [7:0]  cmd_len,
    input  logic        rd_done,
    output logic        rd_abort,
    output logic        buf_sel,
    output logic        mode_q,
    output logic        underrun,
    input  logic        underrun_clr
);

    fetch_state_t state, state_n;

    logic [9:0] next_line;
    logic       on_last_line;
    logic       line_visible;
    logic       frame_end;
    logic       handshake;
    logic       frame_synced;
    logic       line_fetched;
    logic       set_underrun;
    logic       abort_n;
    logic       swap_buf;
    logic       realign;

    assign frame_end    = hmax & vmax;
    assign handshake    = cmd_valid & cmd_ready;
    assign on_last_line = (vpos == v_max(mode_q));
    assign next_line    = on_last_line ? '0 : vpos + 10'd1;
    assign line_visible = (next_line < v_view(mode_q));

    // After reset the beam position is arbitrary; fetching starts only once
    // the line-0 fetch (on the last line of a frame) has been reached.
    logic armed;
    assign armed = frame_synced | on_last_line;

    always_comb begin
        state_n      = state;
        set_underrun = 1'b0;
        abort_n      = 1'b0;
        swap_buf     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && !hmax && armed && line_visible)
                    state_n = ST_WAIT_BLANK;
            end
            ST_WAIT_BLANK: begin
                if (hmax || !enable)
                    state_n = ST_IDLE;
                else if (hpos == h_view(mode_q))
                    state_n = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (hmax) begin
                    set_underrun = 1'b1;
                    state_n      = ST_IDLE;
                end else if (cmd_ready) begin
                    state_n = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (hmax) begin
                    if (rd_done) begin
                        swap_buf = 1'b1;
                    end else begin
                        set_underrun = 1'b1;
                        abort_n      = 1'b1;
                    end
                    state_n = ST_IDLE;
                end else if (rd_done) begin
                    state_n = ST_READY;
                end
            end
            ST_READY: begin
                if (hmax) begin
                    swap_buf = 1'b1;
                    state_n  = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign realign = (state == ST_WAIT_BLANK) && (state_n == ST_ISSUE) && on_last_line;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmd_valid <= 1'b0;
            rd_abort  <= 1'b0;
            buf_sel   <= 1'b0;
            underrun  <= 1'b0;
            mode_q    <= mode;
            cmd_len   <= LINE_BYTES;
        end else begin
            state     <= state_n;
            cmd_valid <= (state_n == ST_ISSUE);
            rd_abort  <= abort_n;
            if (swap_buf)
                buf_sel <= ~buf_sel;
            if (set_underrun)
                underrun <= 1'b1;
            else if (underrun_clr)
                underrun <= 1'b0;
            if (frame_end)
                mode_q <= mode;
        end
    end

    // Line 0 is fetched on the frame's last line, before the frame boundary;
    // the boundary reload therefore keeps that fetch's stride if it went out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_addr     <= BASE_ADDR;
            frame_synced <= 1'b0;
            line_fetched <= 1'b0;
        end else begin
            if (on_last_line)
                frame_synced <= 1'b1;
            line_fetched <= hmax ? 1'b0 : (line_fetched | handshake);
            if (frame_end)
                cmd_addr <= (line_fetched | handshake) ? BASE_ADDR + LINE_STRIDE : BASE_ADDR;
            else if (realign)
                cmd_addr <= BASE_ADDR;
            else if (handshake)
                cmd_addr <= cmd_addr + LINE_STRIDE;
        end
    end

endmodule
